// File: rtl/io_stim_driver.sv
// Table-driven switch/button stimulus sequencer for the RV32I core I/O.
// Each entry applies a sw/btn pattern, holds it, and can wait for the core to echo sw on ledg.
module io_stim_driver #(
   parameter int unsigned DEPTH   = 16,
   parameter int unsigned HOLD_W  = 16,
   parameter int unsigned TIMEOUT = 1000
) (
   input  logic                     i_clk,
   input  logic                     i_rst_n,
   input  logic                     i_load_en,
   input  logic [$clog2(DEPTH)-1:0] i_load_addr,
   input  logic [31:0]              i_load_sw,
   input  logic [31:0]              i_load_btn,
   input  logic [HOLD_W-1:0]        i_load_hold,
   input  logic                     i_load_wait,
   input  logic                     i_load_last,
   input  logic                     i_start,
   input  logic [31:0]              i_io_ledg,
   output logic [31:0]              o_io_sw,
   output logic [31:0]              o_io_btn,
   output logic                     o_busy,
   output logic                     o_done,
   output logic                     o_timeout,
   output logic [$clog2(DEPTH)-1:0] o_step
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

   typedef struct packed {
      logic [31:0]       sw;
      logic [31:0]       btn;
      logic [HOLD_W-1:0] hold;
      logic              wait_en;
      logic              last;
   } entry_t;

   typedef enum logic [2:0] {
      S_IDLE, S_APPLY, S_HOLD, S_WAIT_ACK, S_NEXT, S_DONE, S_ERR
   } state_t;

   state_t            state, state_nxt;
   entry_t            tbl [DEPTH];
   entry_t            cur;
   logic [AW-1:0]     idx;
   logic [HOLD_W-1:0] hold_cnt;
   logic [TW-1:0]     to_cnt;
   logic [31:0]       sw_q, btn_q;
   logic              busy_c;
   logic              start_ok;

   assign cur      = tbl[idx];
   assign busy_c   = (state == S_APPLY) || (state == S_HOLD) ||
                     (state == S_WAIT_ACK) || (state == S_NEXT);
   // A simultaneous load takes precedence over start.
   assign start_ok = i_start && !i_load_en && !busy_c;

   // Pattern table; writes only while idle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         for (int i = 0; i < int'(DEPTH); i++) tbl[i] <= '0;
      end else if (i_load_en && !busy_c) begin
         tbl[i_load_addr] <= '{sw: i_load_sw, btn: i_load_btn, hold: i_load_hold,
                               wait_en: i_load_wait, last: i_load_last};
      end
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   // Next-state logic.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE, S_DONE, S_ERR: if (start_ok) state_nxt = S_APPLY;
         S_APPLY:               state_nxt = S_HOLD;
         S_HOLD: begin
            if (hold_cnt == '0) state_nxt = cur.wait_en ? S_WAIT_ACK : S_NEXT;
         end
         S_WAIT_ACK: begin
            if (i_io_ledg == cur.sw)               state_nxt = S_NEXT;
            else if (to_cnt == TW'(TIMEOUT - 1))   state_nxt = S_ERR;
         end
         S_NEXT: begin
            if (cur.last || (idx == AW'(DEPTH - 1))) state_nxt = S_DONE;
            else                                     state_nxt = S_APPLY;
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // Status outputs decoded from the state register only.
   always_comb begin
      o_busy    = 1'b0;
      o_done    = 1'b0;
      o_timeout = 1'b0;
      case (state)
         S_APPLY, S_HOLD, S_WAIT_ACK, S_NEXT: o_busy    = 1'b1;
         S_DONE:                              o_done    = 1'b1;
         S_ERR:                               o_timeout = 1'b1;
         default: ;
      endcase
   end

   // Sequencer datapath: index, counters and the registered sw/btn drive.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         idx      <= '0;
         hold_cnt <= '0;
         to_cnt   <= '0;
         sw_q     <= '0;
         btn_q    <= '0;
      end else begin
         case (state)
            S_IDLE, S_DONE, S_ERR: if (start_ok) idx <= '0;
            S_APPLY: begin
               sw_q     <= cur.sw;
               btn_q    <= cur.btn;
               hold_cnt <= cur.hold;
            end
            S_HOLD: begin
               if (hold_cnt != '0) hold_cnt <= hold_cnt - HOLD_W'(1);
               to_cnt <= '0;
            end
            S_WAIT_ACK: if (state_nxt == S_WAIT_ACK) to_cnt <= to_cnt + TW'(1);
            S_NEXT:     if (state_nxt == S_APPLY) idx <= idx + AW'(1);
            default: ;
         endcase
         // Buttons are released as the entry finishes or the echo wait fails.
         if ((state_nxt == S_NEXT) || (state_nxt == S_ERR)) btn_q <= '0;
      end
   end

   assign o_io_sw  = sw_q;
   assign o_io_btn = btn_q;
   assign o_step   = idx;

endmodule
